// File: rtl/rv32_clint_pkg.sv
// clint_pkg: shared definitions for the rv32_clint core-local interruptor.
//   - Byte offsets of the memory-mapped registers within the 64 KiB region.
//   - Reset value of the 64-bit mtimecmp register.
//   - apply_be(): merges a byte-lane write into an existing 32-bit word.
package clint_pkg;

    // Byte offsets inside the region. The address word index is compared
    // against these with the low two bits forced to zero.
    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    // mtimecmp resets to all-ones so no timer interrupt fires before
    // software has programmed a deadline.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Each set bit of be replaces the matching byte of old_word with the
    // corresponding byte of new_word.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32_clint_if.sv
// rv32_clint_if: data-bus connection between the core's dbus port and the
// CLINT.
//   dbus_addr   core -> clint  byte address
//   dbus_we     core -> clint  byte write enables
//   dbus_wdata  core -> clint  write data, byte-lane aligned
//   clint_sel   clint -> core  address falls inside the CLINT region
//   clint_rdata clint -> core  read data, combinational
//
// Transfer semantics: there is no valid/ready pair and no back-pressure.
// A write is accepted at every clk_in rising edge where clint_sel is high
// and any dbus_we bit is set. A read is any cycle with clint_sel high:
// clint_rdata is valid in that same cycle and reading has no side effects.
interface rv32_clint_if;

    logic [31:0] dbus_addr;
    logic [3:0]  dbus_we;
    logic [31:0] dbus_wdata;
    logic        clint_sel;
    logic [31:0] clint_rdata;

    modport master (
        output dbus_addr,
        output dbus_we,
        output dbus_wdata,
        input  clint_sel,
        input  clint_rdata
    );

    modport slave (
        input  dbus_addr,
        input  dbus_we,
        input  dbus_wdata,
        output clint_sel,
        output clint_rdata
    );

endinterface

// File: rtl/rv32_clint_prescaler.sv
// clint_prescaler: divides clk_in down to the mtime increment rate.
//   clk_in  in   core clock
//   rst_n   in   asynchronous active-low reset
//   tick    out  high for one clk_in cycle out of every PRESCALE
// PRESCALE must lie in 1..65535; with PRESCALE = 1 tick is constantly high.
module clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt;

    assign tick = (pcnt == LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 16'd0;
        end else if (tick) begin
            pcnt <= 16'd0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/rv32_clint.sv
// rv32_clint: RISC-V core-local interruptor (mtime, mtimecmp, msip).
//   clk_in     in   core clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave side of rv32_clint_if (dbus_addr/we/wdata in,
//              clint_sel/clint_rdata out)
//   timer_irq  out  machine timer interrupt, registered (mtime >= mtimecmp)
//   sw_irq     out  machine software interrupt, registered copy of msip
module rv32_clint
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic         clk_in,
    input  logic         rst_n,
    rv32_clint_if.slave  bus,
    output logic         timer_irq,
    output logic         sw_irq
);

    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic        timer_irq_q;
    logic        sw_irq_q;
    logic        tick;

    logic [15:0] offset;
    logic        wr_en;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic [31:0] rdata;
    logic        addr_unused;

    // Registers are word-addressed; the byte offset within a word is ignored.
    assign offset      = {bus.dbus_addr[15:2], 2'b00};
    assign addr_unused = ^bus.dbus_addr[1:0];

    assign bus.clint_sel = (bus.dbus_addr[31:16] == BASE_ADDR[31:16]);
    assign wr_en         = bus.clint_sel && (|bus.dbus_we);
    assign wr_mtime_lo   = wr_en && (offset == OFF_MTIME_LO);
    assign wr_mtime_hi   = wr_en && (offset == OFF_MTIME_HI);

    clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick   (tick)
    );

    // Read mux from current register contents, so a same-cycle write is not
    // visible until the next cycle.
    always_comb begin
        rdata = 32'h0;
        case (offset)
            OFF_MSIP:        rdata = {31'h0, msip};
            OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
            OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
            OFF_MTIME_LO:    rdata = mtime[31:0];
            OFF_MTIME_HI:    rdata = mtime[63:32];
            default:         rdata = 32'h0;
        endcase
    end

    assign bus.clint_rdata = bus.clint_sel ? rdata : 32'h0;

    // A software write to either half of mtime wins over the tick: the
    // increment is dropped for that cycle and the other half holds.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime_nxt[31:0] = apply_be(mtime[31:0], bus.dbus_wdata, bus.dbus_we);
            end
            if (wr_mtime_hi) begin
                mtime_nxt[63:32] = apply_be(mtime[63:32], bus.dbus_wdata, bus.dbus_we);
            end
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'h0;
        end else begin
            mtime <= mtime_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= MTIMECMP_RESET;
        end else if (wr_en) begin
            if (offset == OFF_MTIMECMP_LO) begin
                mtimecmp[31:0] <= apply_be(mtimecmp[31:0], bus.dbus_wdata, bus.dbus_we);
            end
            if (offset == OFF_MTIMECMP_HI) begin
                mtimecmp[63:32] <= apply_be(mtimecmp[63:32], bus.dbus_wdata, bus.dbus_we);
            end
        end
    end

    // msip lives in bit 0 of lane 0; other lanes cannot touch it.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            msip <= 1'b0;
        end else if (wr_en && (offset == OFF_MSIP) && bus.dbus_we[0]) begin
            msip <= bus.dbus_wdata[0];
        end
    end

    // Level-sensitive interrupts, registered from current register values:
    // they reflect a register update one cycle later.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timer_irq_q <= 1'b0;
            sw_irq_q    <= 1'b0;
        end else begin
            timer_irq_q <= (mtime >= mtimecmp);
            sw_irq_q    <= msip;
        end
    end

    assign timer_irq = timer_irq_q;
    assign sw_irq    = sw_irq_q;

endmodule
